// File: rtl/ov_pkg.sv
// rtl/ov_pkg.sv - shared constants, state encoding and entry decode for the OV init sequencer
package ov_pkg;

    localparam int ENTRY_W   = 16;
    localparam int ROM_DEPTH = 256;
    localparam int ROM_BITS  = ROM_DEPTH * ENTRY_W;

    localparam logic [ENTRY_W-1:0] ENTRY_TERM   = 16'hFFFF;
    localparam logic [7:0]         SUB_DELAY    = 8'hFF;
    localparam logic [7:0]         OV_CHIP_ADDR = 8'h42;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_PWRUP   = 4'd1;
    localparam logic [3:0] ST_FETCH_A = 4'd2;
    localparam logic [3:0] ST_FETCH_D = 4'd3;
    localparam logic [3:0] ST_ISSUE   = 4'd4;
    localparam logic [3:0] ST_WAIT    = 4'd5;
    localparam logic [3:0] ST_GAP     = 4'd6;
    localparam logic [3:0] ST_DELAY   = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;
    localparam logic [3:0] ST_ERROR   = 4'd9;

    typedef enum logic [1:0] {
        ENT_WRITE,
        ENT_DELAY,
        ENT_TERM
    } entry_kind_e;

    function automatic entry_kind_e entry_kind(input logic [ENTRY_W-1:0] e);
        if (e == ENTRY_TERM) return ENT_TERM;
        if (e[ENTRY_W-1 -: 8] == SUB_DELAY) return ENT_DELAY;
        return ENT_WRITE;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov_init_rom.sv
// rtl/ov_init_rom.sv - synchronous register-init table; one cycle read latency
module ov_init_rom
    import ov_pkg::*;
#(
    parameter int                  NUM_ENTRIES = 64,
    parameter bit                  USE_TABLE   = 1'b0,
    parameter logic [ROM_BITS-1:0] TABLE       = '0
) (
    input  logic               clk,
    input  logic [7:0]         idx,
    output logic [ENTRY_W-1:0] entry
);

    function automatic logic [ENTRY_W-1:0] default_entry(input logic [7:0] i);
        case (i)
            8'd0:  return 16'h1280;
            8'd1:  return 16'hFF0A;
            8'd2:  return 16'h1214;
            8'd3:  return 16'h1180;
            8'd4:  return 16'h0C04;
            8'd5:  return 16'h3E19;
            8'd6:  return 16'h0400;
            8'd7:  return 16'h40D0;
            8'd8:  return 16'h3A04;
            8'd9:  return 16'h1418;
            8'd10: return 16'h4FB3;
            8'd11: return 16'h50B3;
            8'd12: return 16'h5100;
            8'd13: return 16'h523D;
            8'd14: return 16'h53A7;
            8'd15: return 16'h54E4;
            8'd16: return 16'h589E;
            8'd17: return 16'h3DC0;
            8'd18: return 16'h1714;
            8'd19: return 16'h1802;
            8'd20: return 16'h3280;
            8'd21: return 16'h1903;
            8'd22: return 16'h1A7B;
            8'd23: return 16'h030A;
            8'd24: return 16'h0F41;
            8'd25: return 16'h1E00;
            8'd26: return 16'h330B;
            8'd27: return 16'h3C78;
            8'd28: return 16'h6900;
            8'd29: return 16'h7400;
            8'd30: return 16'hB084;
            8'd31: return 16'hB10C;
            8'd32: return 16'hB20E;
            8'd33: return 16'hB380;
            8'd34: return 16'h703A;
            8'd35: return 16'h7135;
            8'd36: return 16'h7211;
            8'd37: return 16'h73F0;
            8'd38: return 16'hA202;
            default: return ENTRY_TERM;
        endcase
    endfunction

    // Out-of-range addresses read as a terminator so a short table can never run past its end.
    always_ff @(posedge clk) begin
        if (int'(idx) >= NUM_ENTRIES) begin
            entry <= ENTRY_TERM;
        end else if (USE_TABLE) begin
            entry <= TABLE[{idx, 4'h0} +: ENTRY_W];
        end else begin
            entry <= default_entry(idx);
        end
    end

endmodule

// File: rtl/ov_init_seq.sv
// rtl/ov_init_seq.sv - walks the init table and issues one SCCB write per entry, with delays and timeout
module ov_init_seq
    import ov_pkg::*;
#(
    parameter logic [7:0]          CHIP_ADDR     = OV_CHIP_ADDR,
    parameter int                  NUM_ENTRIES   = 64,
    parameter int                  DELAY_UNIT    = 100000,
    parameter int                  POWERUP_WAIT  = 1000000,
    parameter int                  GAP_CYCLES    = 16,
    parameter int                  TIMEOUT       = 65535,
    parameter bit                  AUTO_START    = 1'b1,
    parameter bit                  USE_ROM_TABLE = 1'b0,
    parameter logic [ROM_BITS-1:0] ROM_TABLE     = '0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_err,
    output logic [7:0] err_index,
    output logic       sccb_start,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_subaddr,
    output logic [7:0] sccb_wdata,
    input  logic       sccb_busy,
    input  logic       sccb_done
);

    localparam int DLY_W = $clog2(255 * longint'(DELAY_UNIT) + 1);
    localparam int CW    = max_int(max_int(DLY_W, $clog2(POWERUP_WAIT + 1)),
                                   max_int($clog2(GAP_CYCLES + 1), $clog2(TIMEOUT + 1)));

    logic [3:0]         state;
    logic [8:0]         idx;
    logic               started;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nx;
    logic [CW-1:0]      dly_len;
    logic [7:0]         dly_q;
    logic [ENTRY_W-1:0] entry;
    entry_kind_e        kind;

    ov_init_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .USE_TABLE   (USE_ROM_TABLE),
        .TABLE       (ROM_TABLE)
    ) u_rom (
        .clk   (clk),
        .idx   (idx[7:0]),
        .entry (entry)
    );

    assign kind    = entry_kind(entry);
    assign cnt_nx  = cnt + CW'(1);
    assign dly_len = CW'(dly_q) * CW'(DELAY_UNIT);

    assign init_busy  = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign init_done  = (state == ST_DONE);
    assign init_err   = (state == ST_ERROR);
    assign sccb_start = (state == ST_ISSUE) && !sccb_busy;
    assign sccb_addr  = CHIP_ADDR;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            started      <= 1'b0;
            cnt          <= '0;
            dly_q        <= '0;
            sccb_subaddr <= '0;
            sccb_wdata   <= '0;
            err_index    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((AUTO_START && !started) || init_start) begin
                        state   <= ST_PWRUP;
                        idx     <= '0;
                        cnt     <= '0;
                        started <= 1'b1;
                    end
                end
                ST_PWRUP: begin
                    if (cnt_nx >= CW'(POWERUP_WAIT)) begin
                        state <= ST_FETCH_A;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                ST_FETCH_A: state <= ST_FETCH_D;
                ST_FETCH_D: begin
                    if (idx == 9'(NUM_ENTRIES) || kind == ENT_TERM) begin
                        state <= ST_DONE;
                    end else if (kind == ENT_DELAY) begin
                        if (entry[7:0] == 8'd0) begin
                            idx   <= idx + 9'd1;
                            state <= ST_FETCH_A;
                        end else begin
                            dly_q <= entry[7:0];
                            cnt   <= '0;
                            state <= ST_DELAY;
                        end
                    end else begin
                        sccb_subaddr <= entry[15:8];
                        sccb_wdata   <= entry[7:0];
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!sccb_busy) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                // cnt holds cycles since the start pulse; a done in the first of them is stale.
                ST_WAIT: begin
                    if (sccb_done && cnt >= CW'(2)) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end else if (cnt_nx >= CW'(TIMEOUT)) begin
                        state     <= ST_ERROR;
                        err_index <= idx[7:0];
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                ST_GAP: begin
                    if (cnt_nx >= CW'(GAP_CYCLES)) begin
                        idx   <= idx + 9'd1;
                        cnt   <= '0;
                        state <= ST_FETCH_A;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                ST_DELAY: begin
                    if (cnt_nx >= dly_len) begin
                        idx   <= idx + 9'd1;
                        cnt   <= '0;
                        state <= ST_FETCH_A;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (init_start) begin
                        state <= ST_PWRUP;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov_init_seq.sv
// tb/tb_ov_init_seq.sv - random-response bench for ov_init_seq against a table-walking timeline model
module tb_ov_init_seq;
    import ov_pkg::*;

    localparam int P = 10, U = 10, G = 4, T = 100, NCYC = 12000;
    localparam int N_A = 8, N_B = 4;
    localparam logic [ROM_BITS-1:0] TAB_A = {3968'd0, 16'h2B11, 16'h3C55, 16'hFFFF, 16'h1101,
                                             16'hFF00, 16'h0AFE, 16'hFF03, 16'h1280};
    localparam logic [ROM_BITS-1:0] TAB_B = {4032'd0, 16'h3C55, 16'h0AFE, 16'h1101, 16'h1280};
    localparam int EV_NONE = 0, EV_START = 1, EV_DONE = 2, EV_ERR = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_start = 1'b0;
    logic [1:0] busy_in = '0, done_in = '0;
    logic [1:0] start_o, ibusy_o, idone_o, ierr_o;
    logic [7:0] addr_o [2];
    logic [7:0] sub_o [2];
    logic [7:0] wd_o [2];
    logic [7:0] eidx_o [2];

    int n_vec = 0, n_err = 0;

    int m_run [2], m_busy_from [2], m_ev [2], m_ev_cyc [2], m_idx [2], m_err_idx [2];
    logic [7:0] m_sub [2], m_dat [2];
    int s_done_at [2], s_stale_at [2], s_busy_until [2];

    always #5 clk = ~clk;

    ov_init_seq #(
        .NUM_ENTRIES(N_A), .DELAY_UNIT(U), .POWERUP_WAIT(P), .GAP_CYCLES(G), .TIMEOUT(T),
        .AUTO_START(1'b1), .USE_ROM_TABLE(1'b1), .ROM_TABLE(TAB_A)
    ) u_dut_a (
        .clk(clk), .reset(reset), .init_start(init_start),
        .init_busy(ibusy_o[0]), .init_done(idone_o[0]), .init_err(ierr_o[0]), .err_index(eidx_o[0]),
        .sccb_start(start_o[0]), .sccb_addr(addr_o[0]), .sccb_subaddr(sub_o[0]), .sccb_wdata(wd_o[0]),
        .sccb_busy(busy_in[0]), .sccb_done(done_in[0])
    );

    ov_init_seq #(
        .NUM_ENTRIES(N_B), .DELAY_UNIT(U), .POWERUP_WAIT(P), .GAP_CYCLES(G), .TIMEOUT(T),
        .AUTO_START(1'b1), .USE_ROM_TABLE(1'b1), .ROM_TABLE(TAB_B)
    ) u_dut_b (
        .clk(clk), .reset(reset), .init_start(init_start),
        .init_busy(ibusy_o[1]), .init_done(idone_o[1]), .init_err(ierr_o[1]), .err_index(eidx_o[1]),
        .sccb_start(start_o[1]), .sccb_addr(addr_o[1]), .sccb_subaddr(sub_o[1]), .sccb_wdata(wd_o[1]),
        .sccb_busy(busy_in[1]), .sccb_done(done_in[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tab_entry(input int u, input int i);
        logic [ROM_BITS-1:0] t;
        t = (u == 0) ? TAB_A : TAB_B;
        return t[i*16 +: 16];
    endfunction

    // From fetch cycle f, skip delay entries and predict the next start or the completion.
    task automatic walk(input int u, input int f0);
        int i, f;
        bit go;
        logic [15:0] e;
        i = m_idx[u];
        f = f0;
        go = 1'b1;
        while (go) begin
            if (i >= ((u == 0) ? N_A : N_B)) begin
                m_ev[u] = EV_DONE; m_ev_cyc[u] = f + 2; go = 1'b0;
            end else begin
                e = tab_entry(u, i);
                if (e == 16'hFFFF) begin
                    m_ev[u] = EV_DONE; m_ev_cyc[u] = f + 2; go = 1'b0;
                end else if (e[15:8] == 8'hFF) begin
                    f = f + 2 + int'(e[7:0]) * U;
                    i++;
                end else begin
                    m_idx[u] = i; m_sub[u] = e[15:8]; m_dat[u] = e[7:0];
                    m_ev[u] = EV_START;
                    m_ev_cyc[u] = (f + 2 > s_busy_until[u] + 1) ? f + 2 : s_busy_until[u] + 1;
                    go = 1'b0;
                end
            end
        end
    endtask

    // Choose the camera's response to a start at cycle s and derive what follows.
    task automatic on_start(input int u, input int s);
        int r, lat, tail;
        r = int'($urandom_range(0, 39));
        if (r < 4) lat = -1;
        else if (r < 7) lat = T - 1;
        else if (r < 9) lat = T;
        else lat = int'($urandom_range(2, 40));
        tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 25)) : int'($urandom_range(0, 3));
        s_stale_at[u] = ($urandom_range(0, 4) == 0) ? s + 1 : -1;
        s_done_at[u] = (lat < 0) ? -1 : s + lat;
        s_busy_until[u] = (lat < 0) ? s + T + tail : s + lat + tail;
        if (lat >= 2 && lat <= T - 1) begin
            m_idx[u]++;
            walk(u, s + lat + G + 1);
        end else begin
            m_ev[u] = EV_ERR; m_ev_cyc[u] = s + T; m_err_idx[u] = m_idx[u];
        end
    endtask

    initial begin
        int rst_hold;
        bit exp_start, fin, exp_busy;
        rst_hold = 0;
        for (int u = 0; u < 2; u++) begin
            m_run[u] = 0; m_ev[u] = EV_NONE; m_ev_cyc[u] = 0; m_idx[u] = 0; m_busy_from[u] = 0;
            m_err_idx[u] = 0; m_sub[u] = '0; m_dat[u] = '0;
            s_done_at[u] = -1; s_stale_at[u] = -1; s_busy_until[u] = -1;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (c < 3) begin
                reset = 1'b1;
            end else if (rst_hold > 0) begin
                reset = 1'b1; rst_hold--;
            end else if ($urandom_range(0, 1199) == 0) begin
                reset = 1'b1; rst_hold = int'($urandom_range(0, 2));
            end else begin
                reset = 1'b0;
            end
            init_start = ($urandom_range(0, 39) == 0);
            for (int u = 0; u < 2; u++) begin
                busy_in[u] = (c <= s_busy_until[u]);
                done_in[u] = (c == s_done_at[u]) || (c == s_stale_at[u]);
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                exp_start = (m_ev[u] == EV_START) && (c == m_ev_cyc[u]);
                fin = (m_ev[u] == EV_DONE || m_ev[u] == EV_ERR) && (c >= m_ev_cyc[u]);
                exp_busy = (m_run[u] != 0) && (c >= m_busy_from[u]) && !fin;
                check_eq($sformatf("u%0d_c%0d_start", u, c), 32'(start_o[u]), 32'(exp_start));
                check_eq($sformatf("u%0d_c%0d_busy", u, c), 32'(ibusy_o[u]), 32'(exp_busy));
                check_eq($sformatf("u%0d_c%0d_done", u, c), 32'(idone_o[u]),
                         32'(m_run[u] != 0 && fin && m_ev[u] == EV_DONE));
                check_eq($sformatf("u%0d_c%0d_err", u, c), 32'(ierr_o[u]),
                         32'(m_run[u] != 0 && fin && m_ev[u] == EV_ERR));
                check_eq($sformatf("u%0d_c%0d_addr", u, c), 32'(addr_o[u]), 32'h42);
                if (exp_start) begin
                    check_eq($sformatf("u%0d_c%0d_subaddr", u, c), 32'(sub_o[u]), 32'(m_sub[u]));
                    check_eq($sformatf("u%0d_c%0d_wdata", u, c), 32'(wd_o[u]), 32'(m_dat[u]));
                end
                if (m_run[u] != 0 && fin && m_ev[u] == EV_ERR)
                    check_eq($sformatf("u%0d_c%0d_err_index", u, c), 32'(eidx_o[u]), 32'(m_err_idx[u]));
                if (m_run[u] == 0) begin
                    check_eq($sformatf("u%0d_c%0d_rst_sub", u, c), 32'(sub_o[u]), 32'h0);
                    check_eq($sformatf("u%0d_c%0d_rst_wdata", u, c), 32'(wd_o[u]), 32'h0);
                    check_eq($sformatf("u%0d_c%0d_rst_eidx", u, c), 32'(eidx_o[u]), 32'h0);
                end

                if (reset) begin
                    m_run[u] = 0; m_ev[u] = EV_NONE;
                    s_done_at[u] = -1; s_stale_at[u] = -1; s_busy_until[u] = -1;
                end else if (exp_start) begin
                    on_start(u, c);
                end else if (m_run[u] == 0 || (fin && init_start)) begin
                    m_run[u] = 1; m_busy_from[u] = c + 1; m_ev[u] = EV_NONE; m_idx[u] = 0;
                    walk(u, c + 1 + P);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
